// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude comparator.
//   state_t   : controller states (IDLE, RUN)
//   SLICE_W   : bits consumed per clock by the cascade slice
//   slice_cmp : 2-bit cascade compare, returns {e_o, g_o}
package cmp_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam int SLICE_W = 2;

  // A differing slice overrides whatever the less-significant bits decided.
  // An equal slice passes the incoming cascade through unchanged.
  function automatic logic [1:0] slice_cmp(
    input logic [SLICE_W-1:0] x,
    input logic [SLICE_W-1:0] y,
    input logic               e_i,
    input logic               g_i
  );
    if (x == y) begin
      return {e_i, g_i};
    end
    return {1'b0, (x > y)};
  endfunction

endpackage

// File: rtl/cmp_slice2.sv
// Combinational 2-bit cascade magnitude slice.
//   x, y : slice bits of operands A and B
//   e_i  : equal-in from the less-significant side
//   g_i  : greater-in from the less-significant side
//   e_o  : equal-out  (x==y) ? e_i : 0
//   g_o  : greater-out (x==y) ? g_i : (x>y)
// Usable standalone in a spatial chain or time-multiplexed.
module cmp_slice2
  import cmp_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               e_i,
  input  logic               g_i,
  output logic               e_o,
  output logic               g_o
);

  assign {e_o, g_o} = slice_cmp(x, y, e_i, g_i);

endmodule

// File: rtl/serial_mag_comparator.sv
// Sequential WIDTH-bit unsigned magnitude comparator.
// One 2-bit cascade slice walks the operands LSB slice first; its outputs
// are fed back as the cascade inputs for the next, more significant slice.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request a compare (only sampled in IDLE)
//   a, b       : operands, captured on an accepted start
//   e_in, g_in : cascade inputs from a less-significant stage, captured on start
//   busy       : comparison in progress
//   done       : one-cycle pulse when eq/gt/lt update
//   eq, gt, lt : registered results, held until the next completion
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             e_in,
  input  logic             g_in,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
    $error("serial_mag_comparator: WIDTH must be even and >= 2");
  end

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sa_reg, sa_next;
  logic [WIDTH-1:0] sb_reg, sb_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             acc_eq_reg, acc_eq_next;
  logic             acc_gt_reg, acc_gt_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             eq_reg, eq_next;
  logic             gt_reg, gt_next;
  logic             valid_reg, valid_next;

  logic             slice_e;
  logic             slice_g;

  // The single time-multiplexed slice always looks at the lowest two bits
  // of the shifting operand copies.
  cmp_slice2 u_slice (
    .x   (sa_reg[SLICE_W-1:0]),
    .y   (sb_reg[SLICE_W-1:0]),
    .e_i (acc_eq_reg),
    .g_i (acc_gt_reg),
    .e_o (slice_e),
    .g_o (slice_g)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      sa_reg     <= '0;
      sb_reg     <= '0;
      cnt_reg    <= '0;
      acc_eq_reg <= 1'b0;
      acc_gt_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      eq_reg     <= 1'b0;
      gt_reg     <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sa_reg     <= sa_next;
      sb_reg     <= sb_next;
      cnt_reg    <= cnt_next;
      acc_eq_reg <= acc_eq_next;
      acc_gt_reg <= acc_gt_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      eq_reg     <= eq_next;
      gt_reg     <= gt_next;
      valid_reg  <= valid_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    sa_next     = sa_reg;
    sb_next     = sb_reg;
    cnt_next    = cnt_reg;
    acc_eq_next = acc_eq_reg;
    acc_gt_next = acc_gt_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    eq_next     = eq_reg;
    gt_next     = gt_reg;
    valid_next  = valid_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          sa_next     = a;
          sb_next     = b;
          acc_eq_next = e_in;
          acc_gt_next = g_in;
          cnt_next    = '0;
          valid_next  = 1'b0;  // drops lt until the new result lands
          busy_next   = 1'b1;
          state_next  = RUN;
        end
      end
      RUN: begin
        acc_eq_next = slice_e;
        acc_gt_next = slice_g;
        sa_next     = sa_reg >> SLICE_W;
        sb_next     = sb_reg >> SLICE_W;
        cnt_next    = cnt_reg + 1'b1;
        if (cnt_reg == LAST_CNT) begin
          eq_next    = slice_e;
          gt_next    = slice_g;
          valid_next = 1'b1;
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign eq   = eq_reg;
  assign gt   = gt_reg;
  assign lt   = valid_reg & ~eq_reg & ~gt_reg;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed plus randomized bench for serial_mag_comparator (WIDTH=8).
// Expected results come from plain integer comparison of the operands and
// the cascade inputs.
module tb_serial_mag_comparator;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         e_in;
  logic         g_in;
  logic         busy;
  logic         done;
  logic         eq;
  logic         gt;
  logic         lt;

  int vectors;
  int miscompares;

  logic prev_eq;
  logic prev_gt;
  logic prev_lt;

  serial_mag_comparator #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .e_in  (e_in),
    .g_in  (g_in),
    .busy  (busy),
    .done  (done),
    .eq    (eq),
    .gt    (gt),
    .lt    (lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One complete comparison; optionally re-pulses start with junk operands
  // during the first two RUN cycles, which must be ignored.
  task automatic run_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic te, input logic tg, input bit repulse);
    logic xe, xg, xl;
    if (ta == tb) begin
      xe = te;
      xg = tg;
    end else begin
      xe = 1'b0;
      xg = (ta > tb);
    end
    xl = ~xe & ~xg;

    a = ta; b = tb; e_in = te; g_in = tg; start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    e_in = 1'($urandom); g_in = 1'($urandom);
    check("accept_busy", busy, 1'b1);
    check("accept_done", done, 1'b0);
    check("accept_lt",   lt,   1'b0);
    check("accept_eq_hold", eq, prev_eq);
    check("accept_gt_hold", gt, prev_gt);

    for (int i = 0; i < W/2 - 1; i++) begin
      if (repulse && i < 2) begin
        start = 1'b1;
        a = W'($urandom); b = W'($urandom);
        e_in = 1'($urandom); g_in = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
      check("run_busy", busy, 1'b1);
      check("run_done", done, 1'b0);
      check("run_eq_hold", eq, prev_eq);
      check("run_gt_hold", gt, prev_gt);
      check("run_lt", lt, 1'b0);
    end
    start = 1'b0;
    tick();
    check("fin_done", done, 1'b1);
    check("fin_busy", busy, 1'b0);
    check("fin_eq", eq, xe);
    check("fin_gt", gt, xg);
    check("fin_lt", lt, xl);
    prev_eq = xe; prev_gt = xg; prev_lt = xl;
    $display("txn a=%02h b=%02h e_in=%b g_in=%b repulse=%0d -> eq=%b gt=%b lt=%b (exp %b%b%b)",
             ta, tb, te, tg, repulse, eq, gt, lt, xe, xg, xl);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         re, rg;
    vectors = 0; miscompares = 0;
    prev_eq = 1'b0; prev_gt = 1'b0; prev_lt = 1'b0;
    rst_n = 1'b0; start = 1'b1; a = '0; b = '0; e_in = 1'b1; g_in = 1'b0;

    // Reset held with start asserted.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_eq", eq, 1'b0);
      check("rst_gt", gt, 1'b0);
      check("rst_lt", lt, 1'b0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_done", done, 1'b0);
    end

    // Directed cases.
    run_cmp(8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0);
    run_cmp(8'h80, 8'h7F, 1'b1, 1'b0, 1'b0);
    run_cmp(8'h01, 8'h02, 1'b1, 1'b0, 1'b0);
    run_cmp(8'h03, 8'h03, 1'b0, 1'b1, 1'b0);   // back-to-back start
    tick();
    check("idle_done_clear", done, 1'b0);
    check("idle_gt_hold", gt, prev_gt);
    run_cmp(8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0);   // illegal cascade corner
    run_cmp(8'h12, 8'hF0, 1'b1, 1'b0, 1'b1);   // start re-pulsed while busy
    tick();
    check("repulse_single_done", done, 1'b0);
    check("repulse_idle", busy, 1'b0);

    // Reset asserted mid-run.
    a = 8'hFF; b = 8'h00; e_in = 1'b1; g_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_eq", eq, 1'b0);
    check("abort_gt", gt, 1'b0);
    check("abort_lt", lt, 1'b0);
    prev_eq = 1'b0; prev_gt = 1'b0; prev_lt = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_no_done", done, 1'b0);
      check("abort_no_busy", busy, 1'b0);
    end
    run_cmp(8'h5A, 8'h5B, 1'b1, 1'b0, 1'b0);

    // Randomized comparisons, a third of them with equal operands so the
    // cascade inputs matter.
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? ra : W'($urandom);
      re = 1'($urandom);
      rg = 1'($urandom);
      run_cmp(ra, rb, re, rg, bit'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) begin
        tick();
        check("rand_idle_done", done, 1'b0);
        check("rand_idle_lt_hold", lt, prev_lt);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
